// File: rtl/req_ack_responder_pkg.sv
// Shared types and limits for the request/acknowledge responder.
package req_ack_responder_pkg;

    localparam int LATENCY_MIN = 1;
    localparam int LATENCY_MAX = 15;
    localparam int CNT_W       = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_e;

endpackage

// File: rtl/req_ack_responder.sv
// Answers each accepted request with one ack pulse LATENCY cycles later, carrying its tag.
// Optional embedded properties are compiled with REQ_ACK_RESPONDER_ASSERTIONS_EN.
module req_ack_responder
    import req_ack_responder_pkg::*;
#(
    parameter int LATENCY = 1,
    parameter int TAG_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_i,
    input  logic [TAG_W-1:0] req_tag_i,
    output logic             ack_o,
    output logic [TAG_W-1:0] ack_tag_o,
    output logic             busy_o,
    output logic             drop_o
);

    generate
        if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : g_bad_latency
            $error("req_ack_responder: LATENCY must be within 1..15");
        end
    endgenerate

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((LATENCY > 1) ? LATENCY - 2 : 0);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [TAG_W-1:0]   ack_tag_q, ack_tag_d;
    logic               drop_q, drop_d;
    logic               accept;

    assign accept = req_i && (state_q != WAIT);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tag_d     = tag_q;
        ack_tag_d = ack_tag_q;
        drop_d    = 1'b0;
        case (state_q)
            WAIT: begin
                drop_d = req_i;
                if (cnt_q == '0) state_d = ACK;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if (accept) begin
            tag_d = req_tag_i;
            if (LATENCY == 1) begin
                state_d = ACK;
            end else begin
                state_d = WAIT;
                cnt_d   = CNT_INIT;
            end
        end
        // The visible tag only changes on entry to ACK so it holds between pulses.
        if (state_d == ACK) ack_tag_d = tag_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            tag_q     <= '0;
            ack_tag_q <= '0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tag_q     <= tag_d;
            ack_tag_q <= ack_tag_d;
            drop_q    <= drop_d;
        end
    end

    assign ack_o     = (state_q == ACK);
    assign busy_o    = (state_q == WAIT);
    assign ack_tag_o = ack_tag_q;
    assign drop_o    = drop_q;

`ifdef REQ_ACK_RESPONDER_ASSERTIONS_EN
    logic past_valid_q;

    always_ff @(posedge clk) begin
        if (rst) past_valid_q <= 1'b0;
        else     past_valid_q <= 1'b1;
    end

    default clocking cb @(posedge clk); endclocking

    a_latency: assert property (disable iff (rst)
        accept |-> ##LATENCY ack_o);
    a_pulse: assert property (disable iff (rst)
        ack_o |=> (!ack_o || (LATENCY == 1)));
    a_drop: assert property (disable iff (rst)
        (past_valid_q && drop_o) |-> $past(busy_o && req_i));
    a_onehot: assert property (disable iff (rst)
        $onehot0({busy_o, ack_o}));
`endif

endmodule

// File: tb/tb_req_ack_responder.sv
// Bench for req_ack_responder: directed tables per latency plus randomized traffic vs an event-time model.
module tb_req_ack_responder;

    localparam int NL = 5;
    localparam int LATS [NL] = '{1, 2, 3, 4, 15};

    typedef struct {
        bit         rst;
        bit         req;
        logic [7:0] tag;
        bit         ack;
        logic [7:0] atag;
        bit         busy;
        bit         drop;
    } vec_t;

    logic       clk;
    logic       rst_v    [NL];
    logic       req_v    [NL];
    logic [7:0] tagin_v  [NL];
    logic       ack_v    [NL];
    logic [7:0] tagout_v [NL];
    logic       busy_v   [NL];
    logic       drop_v   [NL];

    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t tbl[$];

    for (genvar g = 0; g < NL; g++) begin : g_dut
        req_ack_responder #(.LATENCY(LATS[g]), .TAG_W(8)) u_dut (
            .clk      (clk),
            .rst      (rst_v[g]),
            .req_i    (req_v[g]),
            .req_tag_i(tagin_v[g]),
            .ack_o    (ack_v[g]),
            .ack_tag_o(tagout_v[g]),
            .busy_o   (busy_v[g]),
            .drop_o   (drop_v[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic v(input bit rst, input bit req, input logic [7:0] tag,
                     input bit ack, input logic [7:0] atag, input bit busy, input bit drop);
        vec_t r;
        r.rst = rst; r.req = req; r.tag = tag;
        r.ack = ack; r.atag = atag; r.busy = busy; r.drop = drop;
        tbl.push_back(r);
    endtask

    // Each entry drives one edge; expectations are what that edge leaves on the outputs.
    task automatic run_tbl(input int lane, input string name);
        for (int i = 0; i < tbl.size(); i++) begin
            for (int k = 0; k < NL; k++) begin
                rst_v[k] = 1'b1; req_v[k] = 1'b0; tagin_v[k] = 8'h00;
            end
            rst_v[lane]   = tbl[i].rst;
            req_v[lane]   = tbl[i].req;
            tagin_v[lane] = tbl[i].tag;
            @(posedge clk);
            #1;
            chk($sformatf("%s.e%0d.ack", name, i + 1),  8'(ack_v[lane]),  8'(tbl[i].ack));
            chk($sformatf("%s.e%0d.tag", name, i + 1),  tagout_v[lane],    tbl[i].atag);
            chk($sformatf("%s.e%0d.busy", name, i + 1), 8'(busy_v[lane]), 8'(tbl[i].busy));
            chk($sformatf("%s.e%0d.drop", name, i + 1), 8'(drop_v[lane]), 8'(tbl[i].drop));
        end
        tbl.delete();
    endtask

    // Model state: absolute edge at which the pending ack is sampled (-1 = none).
    int         due  [NL];
    logic [7:0] ptag [NL];
    logic [7:0] atag [NL];
    bit         drp  [NL];

    initial begin
        for (int k = 0; k < NL; k++) begin
            rst_v[k] = 1'b1; req_v[k] = 1'b0; tagin_v[k] = 8'h00;
        end

        // L=1 single request
        v(1,0,8'h00, 0,8'h00,0,0);
        v(0,0,8'h00, 0,8'h00,0,0);
        v(0,1,8'h5A, 1,8'h5A,0,0);
        v(0,0,8'h00, 0,8'h5A,0,0);
        v(0,0,8'h00, 0,8'h5A,0,0);
        run_tbl(0, "l1_single");

        // L=3 with refused requests while waiting
        v(1,0,8'h00, 0,8'h00,0,0);
        v(0,1,8'h11, 0,8'h00,1,0);
        v(0,1,8'h22, 0,8'h00,1,1);
        v(0,1,8'h33, 1,8'h11,0,1);
        v(0,0,8'h00, 0,8'h11,0,0);
        v(0,0,8'h00, 0,8'h11,0,0);
        run_tbl(2, "l3_drop");

        // L=1 continuous stream
        v(1,0,8'h00, 0,8'h00,0,0);
        for (int i = 0; i < 8; i++) v(0,1,8'(i), 1,8'(i),0,0);
        v(0,0,8'h00, 0,8'h07,0,0);
        run_tbl(0, "l1_stream");

        // L=2 request in the ACK cycle
        v(1,0,8'h00, 0,8'h00,0,0);
        v(0,1,8'hA1, 0,8'h00,1,0);
        v(0,0,8'h00, 1,8'hA1,0,0);
        v(0,1,8'hB2, 0,8'hA1,1,0);
        v(0,0,8'h00, 1,8'hB2,0,0);
        v(0,0,8'h00, 0,8'hB2,0,0);
        run_tbl(1, "l2_b2b");

        // L=4 reset while pending; request on the reset edge ignored
        v(1,0,8'h00, 0,8'h00,0,0);
        v(0,1,8'h44, 0,8'h00,1,0);
        v(0,0,8'h00, 0,8'h00,1,0);
        v(1,1,8'h55, 0,8'h00,0,0);
        v(0,0,8'h00, 0,8'h00,0,0);
        v(0,0,8'h00, 0,8'h00,0,0);
        v(0,0,8'h00, 0,8'h00,0,0);
        run_tbl(3, "l4_rst");

        // Randomized traffic on all lanes against the event-time model
        for (int k = 0; k < NL; k++) begin
            due[k] = -1; ptag[k] = 8'h00; atag[k] = 8'h00; drp[k] = 1'b0;
        end
        for (int e = 0; e < 3000; e++) begin
            for (int k = 0; k < NL; k++) begin
                rst_v[k]   = (e == 0) || ($urandom_range(0, 199) == 0);
                req_v[k]   = ($urandom_range(0, 99) < ((e / 500) % 2 == 0 ? 70 : 25));
                tagin_v[k] = 8'($urandom);
            end
            @(posedge clk);
            for (int k = 0; k < NL; k++) begin
                if (rst_v[k]) begin
                    due[k] = -1; atag[k] = 8'h00; drp[k] = 1'b0;
                end else begin
                    bit pending;
                    pending = (due[k] > e);
                    drp[k]  = req_v[k] && pending;
                    if (req_v[k] && !pending) begin
                        due[k]  = e + LATS[k];
                        ptag[k] = tagin_v[k];
                    end else if (due[k] == e) begin
                        due[k] = -1;
                    end
                    if (due[k] == e + 1) atag[k] = ptag[k];
                end
            end
            #1;
            for (int k = 0; k < NL; k++) begin
                chk($sformatf("rnd.L%0d.c%0d.ack", LATS[k], e),  8'(ack_v[k]),  8'(due[k] == e + 1));
                chk($sformatf("rnd.L%0d.c%0d.busy", LATS[k], e), 8'(busy_v[k]), 8'(due[k] > e + 1));
                chk($sformatf("rnd.L%0d.c%0d.drop", LATS[k], e), 8'(drop_v[k]), 8'(drp[k]));
                chk($sformatf("rnd.L%0d.c%0d.tag", LATS[k], e),  tagout_v[k],   atag[k]);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
